// File: rtl/apb_pkg.sv
// ---------------------------------------------------------------------------
// apb_pkg
//   Shared APB types for the requester/completer arbiter.
//   apb_h2d_t : requester -> completer fields (psel, penable, pwrite, paddr,
//               pwdata, pstrb)
//   apb_d2h_t : completer -> requester fields (pready, prdata, pslverr)
//   apb_state_e : transfer phase of the shared bus
// ---------------------------------------------------------------------------
package apb_pkg;

    localparam int ApbArbMaxReq = 16;
    localparam int ApbAddrW     = 32;
    localparam int ApbDataW     = 32;
    localparam int ApbStrbW     = ApbDataW / 8;

    typedef struct packed {
        logic                psel;
        logic                penable;
        logic                pwrite;
        logic [ApbAddrW-1:0] paddr;
        logic [ApbDataW-1:0] pwdata;
        logic [ApbStrbW-1:0] pstrb;
    } apb_h2d_t;

    typedef struct packed {
        logic                pready;
        logic [ApbDataW-1:0] prdata;
        logic                pslverr;
    } apb_d2h_t;

    typedef enum logic [1:0] {
        StateIdle,
        StateSetup,
        StateAccess
    } apb_state_e;

endpackage

// File: rtl/apb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// apb_rr_arbiter
//   Round-robin pick among NUM_REQ request lines. The search starts at the
//   rotating pointer and wraps to index 0; the pointer moves to winner+1
//   whenever a grant is taken (i_advance with a valid winner).
//   i_clk, i_rst  : clock, synchronous active-high reset (pointer -> 0)
//   i_req         : request vector
//   i_advance     : grant is being consumed this cycle
//   o_gnt         : one-hot winner (combinational)
//   o_idx         : binary winner index
//   o_valid       : at least one request present
// ---------------------------------------------------------------------------
module apb_rr_arbiter
    import apb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_advance,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_valid
);

    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W:0]   w_cand;

    // One extra bit on the candidate so ptr+offset cannot overflow before
    // the modulo-NUM_REQ fold.
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cand = {1'b0, r_ptr} + (IDX_W+1)'(i);
            if (w_cand >= (IDX_W+1)'(NUM_REQ)) begin
                w_cand = w_cand - (IDX_W+1)'(NUM_REQ);
            end
            if (!o_valid && i_req[w_cand[IDX_W-1:0]]) begin
                o_valid = 1'b1;
                o_idx   = w_cand[IDX_W-1:0];
            end
        end
        if (o_valid) begin
            o_gnt[o_idx] = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= '0;
        end else if (i_advance && o_valid) begin
            r_ptr <= (o_idx == IDX_W'(NUM_REQ-1)) ? '0 : o_idx + 1'b1;
        end
    end

endmodule

// File: rtl/apb_arbiter.sv
// ---------------------------------------------------------------------------
// apb_arbiter
//   Shares one APB completer between NUM_REQ requesters. The round-robin
//   winner's transfer is latched in Idle and replayed as SETUP/ACCESS on the
//   shared bus; the completer response goes back to the winner only. With
//   TIMEOUT_CYCLES>0 a hung ACCESS is closed with pready=1/pslverr=1.
//   clk_i, rst_i : clock, synchronous active-high reset
//   req_i/rsp_o  : requester-side request/response arrays
//   slv_o/slv_i  : shared-bus request/response
//   grant_o      : one-hot bus owner, zero in Idle
//   timeout_o    : one-cycle pulse in the cycle a transfer times out
//
//   state        | meaning
//   StateIdle    | bus quiet, arbitrating; winner latched on any psel
//   StateSetup   | latched transfer on slv_o, psel=1 penable=0
//   StateAccess  | psel=1 penable=1, waiting for pready or timeout
// ---------------------------------------------------------------------------
module apb_arbiter
    import apb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  apb_h2d_t           req_i [NUM_REQ],
    output apb_d2h_t           rsp_o [NUM_REQ],
    output apb_h2d_t           slv_o,
    input  apb_d2h_t           slv_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic               timeout_o
);

    localparam int IdxW = $clog2(NUM_REQ);
    localparam int CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    apb_state_e          r_state;
    apb_state_e          w_state_next;
    apb_h2d_t            r_req;
    logic [NUM_REQ-1:0]  r_grant;
    logic [CntW-1:0]     r_cnt;
    logic [NUM_REQ-1:0]  w_psel;
    logic [NUM_REQ-1:0]  w_gnt;
    logic [IdxW-1:0]     w_idx;
    logic                w_any;
    logic                w_timeout;

    always_comb begin
        w_psel = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_psel[k] = req_i[k].psel;
        end
    end

    apb_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IdxW)
    ) u_rr (
        .i_clk     (clk_i),
        .i_rst     (rst_i),
        .i_req     (w_psel),
        .i_advance (r_state == StateIdle),
        .o_gnt     (w_gnt),
        .o_idx     (w_idx),
        .o_valid   (w_any)
    );

    // r_cnt holds the number of pready=0 ACCESS cycles already seen, so the
    // current cycle is the TIMEOUT_CYCLES-th when r_cnt == TIMEOUT_CYCLES-1.
    // A completer pready in that same cycle takes precedence.
    always_comb begin
        w_timeout = 1'b0;
        if (TIMEOUT_CYCLES > 0 && r_state == StateAccess && !slv_i.pready) begin
            w_timeout = (r_cnt == CntW'(TIMEOUT_CYCLES - 1));
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StateIdle:   if (w_any) w_state_next = StateSetup;
            StateSetup:  w_state_next = StateAccess;
            StateAccess: if (slv_i.pready || w_timeout) w_state_next = StateIdle;
            default:     w_state_next = StateIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= StateIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_req   <= '0;
            r_grant <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                StateIdle: begin
                    if (w_any) begin
                        r_req   <= req_i[w_idx];
                        r_grant <= w_gnt;
                    end
                end
                StateSetup: begin
                    r_cnt <= '0;
                end
                StateAccess: begin
                    if (slv_i.pready || w_timeout) begin
                        r_grant <= '0;
                    end else if (r_cnt != '1) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_grant <= '0;
                end
            endcase
        end
    end

    // slv_o depends only on registered state and the latched request.
    always_comb begin
        slv_o = '0;
        if (r_state != StateIdle) begin
            slv_o         = r_req;
            slv_o.psel    = 1'b1;
            slv_o.penable = (r_state == StateAccess);
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            rsp_o[k] = '0;
            if (r_state == StateAccess && r_grant[k]) begin
                if (w_timeout) begin
                    rsp_o[k].pready  = 1'b1;
                    rsp_o[k].pslverr = 1'b1;
                end else begin
                    rsp_o[k] = slv_i;
                end
            end
        end
    end

    assign grant_o   = r_grant;
    assign timeout_o = w_timeout;

endmodule

// File: tb/tb_apb_arbiter.sv
module tb_apb_arbiter;
    import apb_pkg::*;

    localparam int N   = 3;
    localparam int TMO = 4;

    logic        clk   = 1'b0;
    logic        rst_i = 1'b1;
    apb_h2d_t    req_i [N];
    apb_d2h_t    rsp_o [N];
    apb_h2d_t    slv_o;
    apb_d2h_t    slv_i;
    logic [N-1:0] grant_o;
    logic        timeout_o;

    int n_tests = 0;
    int n_fail  = 0;
    int ptr     = 0;

    logic [31:0] req_addr [N];
    logic [31:0] req_data [N];
    logic        req_wr   [N];
    logic [3:0]  req_strb [N];

    apb_arbiter #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .req_i     (req_i),
        .rsp_o     (rsp_o),
        .slv_o     (slv_o),
        .slv_i     (slv_i),
        .grant_o   (grant_o),
        .timeout_o (timeout_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Round-robin reference: first requester at or after ptr, with wrap.
    function automatic int pick(input logic [N-1:0] mask);
        for (int i = 0; i < N; i++) begin
            int k;
            k = (ptr + i) % N;
            if (mask[k]) return k;
        end
        return -1;
    endfunction

    task automatic check_rsp(input int w, input apb_d2h_t e);
        for (int k = 0; k < N; k++) begin
            if (k == w) check("rsp_winner", 64'(rsp_o[k]), 64'(e));
            else        check("rsp_other", 64'(rsp_o[k]), 64'd0);
        end
    endtask

    task automatic rand_fields(input int k);
        req_addr[k] = $urandom;
        req_data[k] = $urandom;
        req_wr[k]   = 1'($urandom_range(0, 1));
        req_strb[k] = 4'($urandom_range(0, 15));
    endtask

    task automatic drive_req(input logic [N-1:0] mask);
        for (int k = 0; k < N; k++) begin
            req_i[k].psel    = mask[k];
            req_i[k].penable = 1'($urandom_range(0, 1));
            req_i[k].pwrite  = req_wr[k];
            req_i[k].paddr   = req_addr[k];
            req_i[k].pwdata  = req_data[k];
            req_i[k].pstrb   = req_strb[k];
        end
    endtask

    task automatic garbage_slave();
        slv_i.pready  = 1'b1;
        slv_i.prdata  = $urandom;
        slv_i.pslverr = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        slv_i = '0;
        for (int k = 0; k < N; k++) req_i[k] = '0;
        @(negedge clk);
        #1;
        check("rst_grant", 64'(grant_o), 64'd0);
        check("rst_slv", 64'(slv_o), 64'd0);
        check("rst_tmo", 64'(timeout_o), 64'd0);
        check_rsp(-1, '0);
        rst_i = 1'b0;
        ptr   = 0;
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < N; k++) req_i[k].psel = 1'b0;
        slv_i = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
            check("gap_grant", 64'(grant_o), 64'd0);
            check("gap_slv", 64'(slv_o), 64'd0);
        end
    endtask

    // Called from the Idle cycle; returns in the following Idle cycle.
    task automatic do_xfer(input logic [N-1:0] mask, input int delay,
                           input logic [31:0] rdata, input logic err,
                           input bit drop, input int abort_at);
        int       w;
        bit       done;
        apb_d2h_t e;
        logic     et;
        logic [31:0] ea, ed;
        logic     ew;
        logic [3:0] es;

        drive_req(mask);
        garbage_slave();
        #1;
        check("idle_grant", 64'(grant_o), 64'd0);
        check("idle_slv", 64'(slv_o), 64'd0);
        check_rsp(-1, '0);

        w   = pick(mask);
        ea  = req_addr[w];
        ed  = req_data[w];
        ew  = req_wr[w];
        es  = req_strb[w];
        ptr = (w + 1) % N;

        @(negedge clk);
        garbage_slave();
        #1;
        check("setup_grant", 64'(grant_o), 64'd1 << w);
        check("setup_psel", 64'(slv_o.psel), 64'd1);
        check("setup_penable", 64'(slv_o.penable), 64'd0);
        check("setup_paddr", 64'(slv_o.paddr), 64'(ea));
        check("setup_pwdata", 64'(slv_o.pwdata), 64'(ed));
        check("setup_pwrite", 64'(slv_o.pwrite), 64'(ew));
        check("setup_pstrb", 64'(slv_o.pstrb), 64'(es));
        check("setup_tmo", 64'(timeout_o), 64'd0);
        check_rsp(-1, '0);

        // The latched copy must not follow later requester activity.
        for (int k = 0; k < N; k++) begin
            rand_fields(k);
            req_i[k].paddr  = $urandom;
            req_i[k].pwdata = $urandom;
            req_i[k].pwrite = ~req_i[k].pwrite;
            if (drop) req_i[k].psel = 1'b0;
        end

        done = 1'b0;
        for (int c = 1; c <= TMO && !done; c++) begin
            @(negedge clk);
            slv_i = '0;
            if (c == delay + 1) begin
                slv_i.pready  = 1'b1;
                slv_i.prdata  = rdata;
                slv_i.pslverr = err;
            end
            if (abort_at == c) rst_i = 1'b1;
            #1;
            e  = '0;
            et = 1'b0;
            if (c == delay + 1) begin
                e.pready  = 1'b1;
                e.prdata  = rdata;
                e.pslverr = err;
                done      = 1'b1;
            end else if (c == TMO) begin
                e.pready  = 1'b1;
                e.pslverr = 1'b1;
                et        = 1'b1;
                done      = 1'b1;
            end
            check("access_grant", 64'(grant_o), 64'd1 << w);
            check("access_psel", 64'(slv_o.psel), 64'd1);
            check("access_penable", 64'(slv_o.penable), 64'd1);
            check("access_paddr", 64'(slv_o.paddr), 64'(ea));
            check("access_pwdata", 64'(slv_o.pwdata), 64'(ed));
            check("access_pwrite", 64'(slv_o.pwrite), 64'(ew));
            check("access_tmo", 64'(timeout_o), 64'(et));
            check_rsp(w, e);
            if (abort_at == c) begin
                @(negedge clk);
                slv_i = '0;
                #1;
                check("abort_slv", 64'(slv_o), 64'd0);
                check("abort_grant", 64'(grant_o), 64'd0);
                check("abort_tmo", 64'(timeout_o), 64'd0);
                check_rsp(-1, '0);
                rst_i = 1'b0;
                ptr   = 0;
                return;
            end
        end

        @(negedge clk);
        slv_i = '0;
        #1;
        check("post_slv", 64'(slv_o), 64'd0);
        check("post_grant", 64'(grant_o), 64'd0);
        check("post_tmo", 64'(timeout_o), 64'd0);
    endtask

    initial begin
        logic [N-1:0] m;
        slv_i = '0;
        for (int k = 0; k < N; k++) begin
            req_i[k] = '0;
            rand_fields(k);
        end
        do_reset();

        // single write, 3-cycle latency
        req_addr[0] = 32'h0000_0010;
        req_data[0] = 32'hA5A5_0001;
        req_wr[0]   = 1'b1;
        req_strb[0] = 4'hF;
        do_xfer(3'b001, 0, 32'h0, 1'b0, 1'b0, 0);

        // contention from reset: 0,1,0,1
        do_reset();
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < N; k++) rand_fields(k);
            do_xfer(3'b011, $urandom_range(0, 2), $urandom, 1'b0, 1'b0, 0);
        end

        // read with 3 wait states (completer pready coincides with timeout count)
        req_wr[2] = 1'b0;
        do_xfer(3'b100, 3, 32'hDEAD_BEEF, 1'b0, 1'b0, 0);
        do_xfer(3'b100, 2, 32'h1234_5678, 1'b0, 1'b0, 0);

        // timeout: completer never answers
        do_xfer(3'b010, 100, 32'hFFFF_FFFF, 1'b0, 1'b0, 0);

        // completer error pass-through
        do_xfer(3'b001, 1, 32'hCAFE_0000, 1'b1, 1'b0, 0);

        // requester drops psel while granted
        do_xfer(3'b010, 2, 32'h0BAD_F00D, 1'b0, 1'b1, 0);

        // reset during Access, then first grant goes to index 0
        do_xfer(3'b001, 100, 32'h0, 1'b0, 1'b0, 2);
        do_xfer(3'b011, 0, 32'h5555_AAAA, 1'b0, 1'b0, 0);

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
            for (int k = 0; k < N; k++) rand_fields(k);
            m = N'($urandom_range(1, (1 << N) - 1));
            if ($urandom_range(0, 24) == 0) begin
                do_xfer(m, 100, $urandom, 1'b0, 1'b0, $urandom_range(1, TMO - 1));
            end else begin
                do_xfer(m, $urandom_range(0, 6), $urandom, 1'($urandom_range(0, 1)),
                        ($urandom_range(0, 3) == 0), 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
